// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the intersection light controller.
package semaforo_pkg;

  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned ESTADO_W = 3;

  // Phase codes; the numeric values are visible on the estado debug port.
  typedef enum logic [ESTADO_W-1:0] {
    ROJO_INI   = 3'd0,
    P_VERDE    = 3'd1,
    P_AMARILLO = 3'd2,
    ROJO_A     = 3'd3,
    PEATON     = 3'd4,
    L_VERDE    = 3'd5,
    L_AMARILLO = 3'd6,
    ROJO_B     = 3'd7
  } estado_e;

  // One road's lamp head.
  typedef struct packed {
    logic rojo;
    logic amarillo;
    logic verde;
  } lampara_t;

  localparam lampara_t LAMP_ROJO     = lampara_t'(3'b100);
  localparam lampara_t LAMP_AMARILLO = lampara_t'(3'b010);
  localparam lampara_t LAMP_VERDE    = lampara_t'(3'b001);

  // Timer value on whose tick a phase of t ticks ends.
  function automatic logic [TIMER_W-1:0] fin_timer(input int unsigned t);
    return TIMER_W'(t - 32'd1);
  endfunction

  // Main-road head for a given phase.
  function automatic lampara_t lamp_principal(input estado_e s);
    lampara_t l;
    l = LAMP_ROJO;
    if (s == P_VERDE)    l = LAMP_VERDE;
    if (s == P_AMARILLO) l = LAMP_AMARILLO;
    return l;
  endfunction

  // Side-road head for a given phase.
  function automatic lampara_t lamp_lateral(input estado_e s);
    lampara_t l;
    l = LAMP_ROJO;
    if (s == L_VERDE)    l = LAMP_VERDE;
    if (s == L_AMARILLO) l = LAMP_AMARILLO;
    return l;
  endfunction

endpackage

// File: rtl/semaforo_tick.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, free running.
module semaforo_tick #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count raises tick and wraps the counter.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/semaforo_cruce_ctrl.sv
// Demand-driven sequencer for a main road, side road and pedestrian crossing.
module semaforo_cruce_ctrl
  import semaforo_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50,
  parameter int unsigned T_MIN_VERDE = 20,
  parameter int unsigned T_VERDE_LAT = 15,
  parameter int unsigned T_AMARILLO  = 10,
  parameter int unsigned T_TODO_ROJO = 3,
  parameter int unsigned T_PEATON    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_lateral,
  input  logic       boton_peaton,
  output logic       principal_verde,
  output logic       principal_amarillo,
  output logic       principal_rojo,
  output logic       lateral_verde,
  output logic       lateral_amarillo,
  output logic       lateral_rojo,
  output logic       peaton_paso,
  output logic       peaton_pendiente,
  output logic [2:0] estado
);

  localparam logic [TIMER_W-1:0] FIN_MIN_VERDE = fin_timer(T_MIN_VERDE);
  localparam logic [TIMER_W-1:0] FIN_VERDE_LAT = fin_timer(T_VERDE_LAT);
  localparam logic [TIMER_W-1:0] FIN_AMARILLO  = fin_timer(T_AMARILLO);
  localparam logic [TIMER_W-1:0] FIN_TODO_ROJO = fin_timer(T_TODO_ROJO);
  localparam logic [TIMER_W-1:0] FIN_PEATON    = fin_timer(T_PEATON);

  estado_e             state_q;
  estado_e             state_d;
  logic [TIMER_W-1:0]  timer_q;
  logic [TIMER_W-1:0]  timer_d;
  logic                peaton_pendiente_q;
  logic                peaton_pendiente_d;
  logic                tick;
  lampara_t            principal_l;
  lampara_t            lateral_l;

  semaforo_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ROJO_INI;
    else        state_q <= state_d;
  end

  // Next phase; every exit happens on a tick at the phase's final timer value.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ROJO_INI: begin
        if (tick && timer_q == FIN_TODO_ROJO) state_d = P_VERDE;
      end
      P_VERDE: begin
        if (tick && timer_q >= FIN_MIN_VERDE &&
            (sensor_lateral || peaton_pendiente_q)) state_d = P_AMARILLO;
      end
      P_AMARILLO: begin
        if (tick && timer_q == FIN_AMARILLO) state_d = ROJO_A;
      end
      ROJO_A: begin
        if (tick && timer_q == FIN_TODO_ROJO) begin
          if (peaton_pendiente_q)  state_d = PEATON;
          else if (sensor_lateral) state_d = L_VERDE;
          else                     state_d = ROJO_B;
        end
      end
      PEATON: begin
        if (tick && timer_q == FIN_PEATON) begin
          if (sensor_lateral) state_d = L_VERDE;
          else                state_d = ROJO_B;
        end
      end
      L_VERDE: begin
        if (tick && timer_q == FIN_VERDE_LAT) state_d = L_AMARILLO;
      end
      L_AMARILLO: begin
        if (tick && timer_q == FIN_AMARILLO) state_d = ROJO_B;
      end
      ROJO_B: begin
        if (tick && timer_q == FIN_TODO_ROJO) state_d = P_VERDE;
      end
    endcase
  end

  // Phase timer restarts on each phase change and saturates while main rests green.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)            timer_d = '0;
    else if (tick && timer_q != '1)    timer_d = timer_q + TIMER_W'(1);
  end

  // Pedestrian request: entering the walk phase consumes it; presses during walk are dropped.
  always_comb begin
    peaton_pendiente_d = peaton_pendiente_q;
    if (state_d == PEATON && state_q != PEATON)  peaton_pendiente_d = 1'b0;
    else if (boton_peaton && state_q != PEATON) peaton_pendiente_d = 1'b1;
  end

  // Timer and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q            <= '0;
      peaton_pendiente_q <= 1'b0;
    end else begin
      timer_q            <= timer_d;
      peaton_pendiente_q <= peaton_pendiente_d;
    end
  end

  // Moore lamp decode from the state register.
  always_comb begin
    principal_l = lamp_principal(state_q);
    lateral_l   = lamp_lateral(state_q);
    peaton_paso = (state_q == PEATON);
  end

  assign principal_verde    = principal_l.verde;
  assign principal_amarillo = principal_l.amarillo;
  assign principal_rojo     = principal_l.rojo;
  assign lateral_verde      = lateral_l.verde;
  assign lateral_amarillo   = lateral_l.amarillo;
  assign lateral_rojo       = lateral_l.rojo;
  assign peaton_pendiente   = peaton_pendiente_q;
  assign estado             = state_q;

endmodule

// File: tb/tb_semaforo_cruce_ctrl.sv
// Directed bench for the intersection controller, TICK_DIV = 4.
module tb_semaforo_cruce_ctrl;

  localparam int TDIV = 4;

  logic       clk;
  logic       rst_n;
  logic       sensor_lateral;
  logic       boton_peaton;
  logic       principal_verde, principal_amarillo, principal_rojo;
  logic       lateral_verde, lateral_amarillo, lateral_rojo;
  logic       peaton_paso;
  logic       peaton_pendiente;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  semaforo_cruce_ctrl #(
    .TICK_DIV    (TDIV),
    .T_MIN_VERDE (20),
    .T_VERDE_LAT (15),
    .T_AMARILLO  (10),
    .T_TODO_ROJO (3),
    .T_PEATON    (12)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .sensor_lateral     (sensor_lateral),
    .boton_peaton       (boton_peaton),
    .principal_verde    (principal_verde),
    .principal_amarillo (principal_amarillo),
    .principal_rojo     (principal_rojo),
    .lateral_verde      (lateral_verde),
    .lateral_amarillo   (lateral_amarillo),
    .lateral_rojo       (lateral_rojo),
    .peaton_paso        (peaton_paso),
    .peaton_pendiente   (peaton_pendiente),
    .estado             (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected {pv,pa,pr,lv,la,lr,paso} for each phase code.
  function automatic logic [6:0] lamps_exp(input logic [2:0] s);
    case (s)
      3'd1:    return 7'b100_001_0;
      3'd2:    return 7'b010_001_0;
      3'd4:    return 7'b001_001_1;
      3'd5:    return 7'b001_100_0;
      3'd6:    return 7'b001_010_0;
      default: return 7'b001_001_0;
    endcase
  endfunction

  function automatic logic [6:0] lamps_act();
    return {principal_verde, principal_amarillo, principal_rojo,
            lateral_verde, lateral_amarillo, lateral_rojo, peaton_paso};
  endfunction

  // Lamp decode and exclusivity on every cycle.
  always @(negedge clk) begin
    chk("lamps", 32'(lamps_act()), 32'(lamps_exp(estado)));
  end

  // Wait for estado to change; dur = cycles spent since the call.
  task automatic wait_change(output logic [2:0] st, output int dur);
    logic [2:0] prev;
    prev = estado;
    st   = prev;
    dur  = 0;
    while (dur < 5000) begin
      @(negedge clk);
      dur++;
      if (estado != prev) begin
        st = estado;
        return;
      end
    end
    chk("wait_change", 32'(estado != prev), 1);
  endtask

  task automatic expect_phase(input string tag, input logic [2:0] exp_st, input int exp_dur);
    logic [2:0] st;
    int         dur;
    wait_change(st, dur);
    chk({tag, "_st"}, 32'(st), 32'(exp_st));
    chk({tag, "_dur"}, 32'(dur), 32'(exp_dur));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_estado", 32'(estado), 0);
    chk("rst_pend", 32'(peaton_pendiente), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    rst_n          = 1'b0;
    sensor_lateral = 1'b0;
    boton_peaton   = 1'b0;
    repeat (3) @(negedge clk);

    // Idle: all red 3 ticks, then rest in main green.
    chk("t1_rst_estado", 32'(estado), 0);
    chk("t1_rst_pend", 32'(peaton_pendiente), 0);
    rst_n = 1'b1;
    expect_phase("t1_ini", 3'd1, 3 * TDIV);
    repeat (1000) @(negedge clk);
    chk("t1_hold", 32'(estado), 1);

    // Side-road demand from the start: full vehicle cycle.
    sensor_lateral = 1'b1;
    do_reset();
    expect_phase("t2_pv", 3'd1, 3 * TDIV);
    expect_phase("t2_pa", 3'd2, 20 * TDIV);
    expect_phase("t2_ra", 3'd3, 10 * TDIV);
    expect_phase("t2_lv", 3'd5, 3 * TDIV);
    expect_phase("t2_la", 3'd6, 15 * TDIV);
    expect_phase("t2_rb", 3'd7, 10 * TDIV);
    expect_phase("t2_pv2", 3'd1, 3 * TDIV);

    // Single pedestrian pulse, no side traffic.
    sensor_lateral = 1'b0;
    do_reset();
    expect_phase("t3_pv", 3'd1, 3 * TDIV);
    repeat (5 * TDIV) @(negedge clk);
    chk("t3_pend_pre", 32'(peaton_pendiente), 0);
    boton_peaton = 1'b1;
    @(negedge clk);
    boton_peaton = 1'b0;
    chk("t3_pend_set", 32'(peaton_pendiente), 1);
    expect_phase("t3_pa", 3'd2, 20 * TDIV - 5 * TDIV - 1);
    expect_phase("t3_ra", 3'd3, 10 * TDIV);
    expect_phase("t3_pe", 3'd4, 3 * TDIV);
    chk("t3_pend_clr", 32'(peaton_pendiente), 0);
    chk("t3_paso", 32'(peaton_paso), 1);
    expect_phase("t3_rb", 3'd7, 12 * TDIV);
    expect_phase("t3_pv2", 3'd1, 3 * TDIV);
    chk("t3_pend_end", 32'(peaton_pendiente), 0);

    // Button held through the walk phase with side traffic present.
    sensor_lateral = 1'b1;
    do_reset();
    expect_phase("t4_pv", 3'd1, 3 * TDIV);
    boton_peaton = 1'b1;
    expect_phase("t4_pa", 3'd2, 20 * TDIV);
    chk("t4_pend_set", 32'(peaton_pendiente), 1);
    expect_phase("t4_ra", 3'd3, 10 * TDIV);
    expect_phase("t4_pe", 3'd4, 3 * TDIV);
    chk("t4_pend_clr", 32'(peaton_pendiente), 0);
    bad = 0;
    for (int i = 0; i < 12 * TDIV - 1; i++) begin
      @(negedge clk);
      if (peaton_pendiente !== 1'b0 || estado !== 3'd4) bad++;
    end
    chk("t4_no_relatch", 32'(bad), 0);
    @(negedge clk);
    chk("t4_lv", 32'(estado), 5);
    chk("t4_pend_exit", 32'(peaton_pendiente), 0);
    @(negedge clk);
    chk("t4_pend_relatch", 32'(peaton_pendiente), 1);
    boton_peaton = 1'b0;

    // Asynchronous reset in the middle of side green.
    repeat (20) @(negedge clk);
    chk("t5_pre", 32'(estado), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_estado", 32'(estado), 0);
    chk("t5_async_lamps", 32'(lamps_act()), 32'(7'b001_001_0));
    chk("t5_async_pend", 32'(peaton_pendiente), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    expect_phase("t5_pv", 3'd1, 3 * TDIV);
    expect_phase("t5_pa", 3'd2, 20 * TDIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/semaforo_cruce_ctrl.md
Name: semaforo_cruce_ctrl

Overview:
- Sequencing controller for a two-road intersection: main road (principal) and side road (lateral), plus a pedestrian crossing.
- Replaces a free-running fixed-cycle light with a demand-driven scheduler.
  - Main road rests in green.
  - The side-road car sensor or the pedestrian button requests service.
  - All-red clearance intervals separate every conflicting phase.
- All timing is in prescaled ticks derived from the board clock.

Parameters:
- TICK_DIV, 50, clk cycles per timing tick (≥2).
- T_MIN_VERDE, 20, minimum main-green duration in ticks before a request is honoured.
- T_VERDE_LAT, 15, side-road green duration in ticks.
- T_AMARILLO, 10, yellow duration in ticks (both roads).
- T_TODO_ROJO, 3, all-red clearance duration in ticks.
- T_PEATON, 12, pedestrian walk duration in ticks.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sensor_lateral  input  1  side-road vehicle present; level, synchronous to clk.
- boton_peaton  input  1  pedestrian button; level, may be held for many cycles.
- principal_verde / principal_amarillo / principal_rojo  output  1 each  main-road lamps.
- lateral_verde / lateral_amarillo / lateral_rojo  output  1 each  side-road lamps.
- peaton_paso  output  1  pedestrian walk lamp.
- peaton_pendiente  output  1  pedestrian request latched and not yet served.
- estado  output  3  current state code, for debug.

Behaviour:
- Reset: asynchronous on rst_n low; state = ROJO_INI; prescaler, timer and peaton_pendiente cleared.
  - Lamp outputs during reset: all rojo = 1, all other lamps = 0, peaton_paso = 0.
- Prescaler: counts 0..TICK_DIV-1. tick = 1 for one clk when the count = TICK_DIV-1, then wraps to 0.
- Timer: 8-bit tick counter, cleared on every state change, incremented on tick. Leaving a timed state of duration T occurs on the tick where timer = T-1. The prescaler is not reset on a state change.
- State codes: ROJO_INI 0, P_VERDE 1, P_AMARILLO 2, ROJO_A 3, PEATON 4, L_VERDE 5, L_AMARILLO 6, ROJO_B 7.
- Transitions:
  - ROJO_INI → P_VERDE after T_TODO_ROJO ticks.
  - P_VERDE → P_AMARILLO on a tick where timer ≥ T_MIN_VERDE-1 and (sensor_lateral or peaton_pendiente). Otherwise hold indefinitely; the timer saturates at 255.
  - P_AMARILLO → ROJO_A after T_AMARILLO.
  - ROJO_A → PEATON if peaton_pendiente, else L_VERDE if sensor_lateral, else ROJO_B; after T_TODO_ROJO.
  - PEATON → L_VERDE if sensor_lateral, else ROJO_B; after T_PEATON.
  - L_VERDE → L_AMARILLO after T_VERDE_LAT, regardless of sensor.
  - L_AMARILLO → ROJO_B after T_AMARILLO.
  - ROJO_B → P_VERDE after T_TODO_ROJO.
- Lamp decode is Moore, combinational from the state register, so lamps change in the same cycle as estado.
  - Exactly one of the three lamps per road is 1 at all times.
  - principal_verde or principal_amarillo is 1 only in P_VERDE / P_AMARILLO.
  - lateral_verde or lateral_amarillo is 1 only in L_VERDE / L_AMARILLO.
  - peaton_paso = 1 only in PEATON.
- peaton_pendiente:
  - Set on any clk with boton_peaton = 1 while state ≠ PEATON.
  - Cleared on the cycle the state enters PEATON.
  - Button presses during PEATON are ignored.
  - A press in the same cycle as the ROJO_A→PEATON transition is absorbed by the clear; it is not re-latched.
- sensor_lateral is sampled only at decision ticks; it is not latched.
- rst_n asserted mid-phase returns immediately to ROJO_INI with all lamps red.

Decomposition:
- Shared package semaforo_pkg holds:
  - the state enum and codes;
  - the lamp triple type {rojo, amarillo, verde};
  - timer width 8.
- One sub-module: semaforo_tick, the prescaler. Parameter TICK_DIV; ports clk, rst_n, tick.

Test Plan:
- Reset release with no requests (TICK_DIV=4, T_TODO_ROJO=3): all red for 12 clk, then P_VERDE. Remains in P_VERDE for 1000 clk; estado = 1.
- sensor_lateral held 1 from start (T_MIN_VERDE=20): P_VERDE lasts exactly 20 ticks. Then the full sequence runs: P_AMARILLO 10, ROJO_A 3, L_VERDE 15, L_AMARILLO 10, ROJO_B 3, back to P_VERDE. Check lamp exclusivity every cycle.
- One-cycle boton_peaton pulse at tick 5 of P_VERDE, sensor 0: peaton_pendiente = 1 next cycle. At tick 20 the sequence goes to P_AMARILLO, ROJO_A, then PEATON for 12 ticks with peaton_paso = 1. peaton_pendiente clears on PEATON entry; ROJO_B follows, then P_VERDE.
- Button held through PEATON and sensor_lateral = 1: no re-latch during PEATON; PEATON → L_VERDE. peaton_pendiente re-sets the first cycle after leaving PEATON.
- rst_n pulled low for 1 clk mid-L_VERDE: outputs go all-red asynchronously and estado = 0; the sequence restarts from ROJO_INI.
